sum_collector: RTL

Downstream stage of the 12-bit adder: captures each one-cycle `valid`/`y` result pulse into a small show-ahead FIFO and presents it to the consumer over a ready/valid handshake. Keeps a running total of consumed sums, an occupancy count, and sticky overflow and drop tracking. The adder cannot be back-pressured, so this block absorbs bursts and records any loss.

---
 rtl/sum_collector.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sum_collector.sv
// sum_collector
// -------------
// Downstream stage of the 12-bit adder. Each one-cycle in_valid/in_data
// result is captured into a small show-ahead FIFO and offered to the
// consumer over a ready/valid handshake. The block also keeps a running
// total of consumed sums, the occupancy count, and sticky drop tracking.
// The adder cannot be stalled, so a push arriving while the FIFO is full
// (and nothing is popped that cycle) is discarded and recorded.
//
// Handshake: the head entry is transferred on a rising edge where
// out_valid && out_ready are both 1. out_valid never depends on out_ready,
// and once asserted it stays asserted with the same out_data until that
// transfer (or reset). in_valid has no ready; it is a fire-and-forget
// strobe.
//
// Configuration macro: SUM_COLLECTOR_SATURATE_EN
//   defined   -> acc saturates at 2^ACC_W-1 and holds there until reset
//   undefined -> acc wraps modulo 2^ACC_W
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   one-cycle result strobe
//   in_data    in   W-bit sum, sampled when in_valid=1
//   out_valid  out  FIFO head is valid (count != 0)
//   out_data   out  FIFO head value (don't-care when out_valid=0)
//   out_ready  in   consumer accepts the head this cycle
//   count      out  current occupancy, 0..DEPTH
//   acc        out  running total of popped values
//   ovf        out  sticky: at least one push was dropped
//   drop_cnt   out  dropped push count, saturates at 255
//   ovf_clr    in   synchronous clear of ovf and drop_cnt
//   dbg_state  out  occupancy state: 0 EMPTY, 1 PARTIAL, 2 FULL

module sum_collector #(
  parameter int W     = 12,
  parameter int DEPTH = 4,
  parameter int ACC_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [W-1:0]               in_data,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [ACC_W-1:0]           acc,
  output logic                       ovf,
  output logic [7:0]                 drop_cnt,
  input  logic                       ovf_clr,
  output logic [1:0]                 dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } occ_state_t;

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  occ_state_t       state_q, state_d;

  logic             pop;
  logic             push;
  logic             drop;
  logic [ACC_W:0]   acc_sum;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop  = (count_q != '0) && out_ready;
  assign push = in_valid && ((count_q != FULL_CNT) || pop);
  assign drop = in_valid && (count_q == FULL_CNT) && !pop;

  // One extra bit catches the carry out of the accumulator.
  assign acc_sum = {1'b0, acc_q} + {{(ACC_W + 1 - W){1'b0}}, out_data};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    state_d    = state_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    if (pop) begin
`ifdef SUM_COLLECTOR_SATURATE_EN
      acc_d = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
      acc_d = acc_sum[ACC_W-1:0];
`endif
    end

    if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
    // Clear wins over a drop in the same cycle.
    if (ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = 8'd0;
    end

    if (count_d == '0)            state_d = S_EMPTY;
    else if (count_d == FULL_CNT) state_d = S_FULL;
    else                          state_d = S_PARTIAL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
      state_q    <= S_EMPTY;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
    end
  end

  // Storage contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign acc       = acc_q;
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_cnt_q;
  assign dbg_state = state_q;

endmodule
